sort_stream_n: RTL and testbench

- Parametrised, clocked successor to the team's 8-input combinational ascending sorter.
- Accepts one N-lane vector per transaction over a valid/ready handshake and sorts it in place by odd-even transposition, one compare-exchange phase per cycle.
- Returns the sorted vector together with a swap count, which equals the input's inversion count.
- Sort direction (ascending/descending) is selected per transaction.
- Sits between a lane-vector producer and a consumer where the area of a full combinational network is not justified.

---
 rtl/sort_stream_pkg.sv | 21 ++
 rtl/cmp_swap.sv | 17 +
 rtl/sort_stream_n.sv | 113 +++++++++++
 tb/tb_sort_stream_n.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_stream_pkg.sv
// Shared types and width helpers for the streaming odd-even transposition sorter.
package sort_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Swap count is bounded by the maximum inversion count N(N-1)/2.
    function automatic int swap_cnt_w(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

    function automatic int phase_w(input int n);
        return $clog2(n);
    endfunction

    localparam int PHASE_W_DEFAULT = phase_w(8);

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange cell; the strict comparison keeps equal elements in order.
module cmp_swap #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo_or_first,
    output logic [W-1:0] hi_or_second,
    output logic         swapped
);

    assign swapped      = desc ? (a < b) : (a > b);
    assign lo_or_first  = swapped ? b : a;
    assign hi_or_second = swapped ? a : b;

endmodule

// File: rtl/sort_stream_n.sv
// Streaming N-lane sorter: one odd-even transposition phase per cycle, N phases per
// vector, returning the sorted lanes plus the number of exchanges performed.
module sort_stream_n
    import sort_stream_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int CW = swap_cnt_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_desc,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [CW-1:0]  out_swaps
);

    localparam int PW = phase_w(N);

    state_e              state_q, state_d;
    logic [N-1:0][W-1:0] lanes_q, even_nxt, odd_nxt, phase_nxt;
    logic [N-2:0]        even_sw, odd_sw, phase_sw;
    logic [CW-1:0]       swaps_q, phase_cnt;
    logic [PW-1:0]       phase_q;
    logic                desc_q, accept, last_phase;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign last_phase = (phase_q == PW'(N - 1));

    // Pair j compares lanes j and j+1: even j belongs to even phases, odd j to odd phases.
    for (genvar j = 0; j < N - 1; j++) begin : g_pair
        if (j % 2 == 0) begin : g_even
            cmp_swap #(.W(W)) u_cs (
                .a           (lanes_q[j]),
                .b           (lanes_q[j+1]),
                .desc        (desc_q),
                .lo_or_first (even_nxt[j]),
                .hi_or_second(even_nxt[j+1]),
                .swapped     (even_sw[j])
            );
            assign odd_sw[j] = 1'b0;
        end else begin : g_odd
            cmp_swap #(.W(W)) u_cs (
                .a           (lanes_q[j]),
                .b           (lanes_q[j+1]),
                .desc        (desc_q),
                .lo_or_first (odd_nxt[j]),
                .hi_or_second(odd_nxt[j+1]),
                .swapped     (odd_sw[j])
            );
            assign even_sw[j] = 1'b0;
        end
    end

    assign odd_nxt[0] = lanes_q[0];
    if (N % 2 == 1) begin : g_even_tail
        assign even_nxt[N-1] = lanes_q[N-1];
    end else begin : g_odd_tail
        assign odd_nxt[N-1] = lanes_q[N-1];
    end

    always_comb begin
        phase_sw  = phase_q[0] ? odd_sw  : even_sw;
        phase_nxt = phase_q[0] ? odd_nxt : even_nxt;
        phase_cnt = '0;
        for (int i = 0; i < N - 1; i++) begin
            phase_cnt = phase_cnt + CW'(phase_sw[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)     state_d = SORT;
            SORT:    if (last_phase) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
            desc_q  <= 1'b0;
            swaps_q <= '0;
            phase_q <= '0;
        end else if (accept) begin
            lanes_q <= in_data;
            desc_q  <= in_desc;
            swaps_q <= '0;
            phase_q <= '0;
        end else if (state_q == SORT) begin
            lanes_q <= phase_nxt;
            swaps_q <= swaps_q + phase_cnt;
            phase_q <= phase_q + 1'b1;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = lanes_q;
    assign out_swaps = swaps_q;

endmodule

// File: tb/tb_sort_stream_n.sv
// Scoreboard bench for sort_stream_n at N=8 and N=5 against a stable insertion-sort
// and pairwise inversion-count model.
module tb_sort_stream_n;
    import sort_stream_pkg::*;

    localparam int W   = 8;
    localparam int NA  = 8;
    localparam int NB  = 5;
    localparam int CWA = swap_cnt_w(NA);
    localparam int CWB = swap_cnt_w(NB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_in_valid = 0, a_in_desc = 0, a_out_ready = 0;
    logic            a_in_ready, a_out_valid;
    logic [NA*W-1:0] a_in_data = '0, a_out_data;
    logic [CWA-1:0]  a_out_swaps;
    logic            b_in_valid = 0, b_in_desc = 0, b_out_ready = 0;
    logic            b_in_ready, b_out_valid;
    logic [NB*W-1:0] b_in_data = '0, b_out_data;
    logic [CWB-1:0]  b_out_swaps;

    sort_stream_n #(.W(W), .N(NA)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_desc(a_in_desc), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_swaps(a_out_swaps)
    );

    sort_stream_n #(.W(W), .N(NB)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_desc(b_in_desc), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_swaps(b_out_swaps)
    );

    typedef struct {
        logic [63:0] data;
        logic [31:0] swaps;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? a_in_ready : b_in_ready;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? a_out_valid : b_out_valid;
    endfunction

    function automatic logic [63:0] get_data(input int sel);
        return (sel == 0) ? a_out_data : {24'd0, b_out_data};
    endfunction

    function automatic logic [31:0] get_swaps(input int sel);
        return (sel == 0) ? {{(32-CWA){1'b0}}, a_out_swaps} : {{(32-CWB){1'b0}}, b_out_swaps};
    endfunction

    function automatic logic [63:0] pack(input int v[8]);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v[i]);
        return r;
    endfunction

    // Reference: inversions counted pairwise, order from a stable insertion sort.
    function automatic exp_t model(input int n, input logic [63:0] din, input logic desc);
        exp_t e;
        int   v[8];
        int   inv = 0;
        for (int i = 0; i < 8; i++) v[i] = (i < n) ? int'(din[i*8 +: 8]) : 0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (desc ? (v[i] < v[j]) : (v[i] > v[j])) inv++;
        for (int i = 1; i < n; i++) begin
            int key = v[i];
            int j = i - 1;
            while (j >= 0 && (desc ? (v[j] < key) : (v[j] > key))) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = key;
        end
        e.data = '0;
        for (int i = 0; i < n; i++) e.data[i*8 +: 8] = 8'(v[i]);
        e.swaps = 32'(inv);
        return e;
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic d, input logic [63:0] data);
        if (sel == 0) begin
            a_in_valid = v; a_in_desc = d; a_in_data = data;
        end else begin
            b_in_valid = v; b_in_desc = d; b_in_data = data[NB*W-1:0];
        end
    endtask

    task automatic set_out_ready(input int sel, input logic r);
        if (sel == 0) a_out_ready = r;
        else          b_out_ready = r;
    endtask

    task automatic push_exp(input int sel, input logic [63:0] data, input logic desc);
        sb.push_back(model((sel == 0) ? NA : NB, data, desc));
    endtask

    // Offers a vector and returns #1 after the edge that accepts it.
    task automatic accept(input int sel, input logic [63:0] data, input logic desc);
        int waited = 0;
        push_exp(sel, data, desc);
        drive_in(sel, 1'b1, desc, data);
        while (!get_ready(sel) && waited < 64) begin
            @(posedge clk); #1; waited++;
        end
        n_chk++;
        if (get_ready(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: in_ready=%b required 1", get_ready(sel));
        end
        @(posedge clk); #1;
        drive_in(sel, 1'b0, desc, data);
    endtask

    // lat = edge at which the consumer first samples out_valid=1, counted from the accept edge.
    task automatic wait_done(input int sel, output int lat);
        int edges = 0;
        lat = -1;
        while (edges < 64) begin
            @(posedge clk); #1; edges++;
            if (get_valid(sel) === 1'b1) begin
                lat = edges + 1;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: out_valid never rose within %0d edges", edges);
        end
    endtask

    task automatic check_out(input int sel, input string name);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty with out_valid=%b", name, get_valid(sel));
            return;
        end
        e = sb.pop_front();
        n_chk++;
        if (get_data(sel) !== e.data) begin
            n_fail++;
            $display("FAIL %s data: got %h required %h", name, get_data(sel), e.data);
        end
        n_chk++;
        if (get_swaps(sel) !== e.swaps) begin
            n_fail++;
            $display("FAIL %s swaps: got %0d required %0d", name, get_swaps(sel), e.swaps);
        end
        set_out_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_out_ready(sel, 1'b0);
        n_chk++;
        if (get_valid(sel) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b required 0", name, get_valid(sel));
        end
    endtask

    task automatic run(input int sel, input logic [63:0] data, input logic desc, input string name);
        int lat;
        int n = (sel == 0) ? NA : NB;
        accept(sel, data, desc);
        wait_done(sel, lat);
        n_chk++;
        if (lat != n + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges required %0d", name, lat, n + 1);
        end
        check_out(sel, name);
    endtask

    task automatic test_reset;
        #2;
        n_chk++;
        if ({a_in_ready, a_out_valid, b_in_ready, b_out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: a_rdy=%b a_vld=%b b_rdy=%b b_vld=%b required 0", a_in_ready, a_out_valid, b_in_ready, b_out_valid);
        end
        n_chk++;
        if (a_out_data !== '0 || a_out_swaps !== '0 || b_out_data !== '0 || b_out_swaps !== '0) begin
            n_fail++;
            $display("FAIL reset_data: a=%h/%0d b=%h/%0d required 0", a_out_data, a_out_swaps, b_out_data, b_out_swaps);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: a_rdy=%b b_rdy=%b required 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_reverse;
        int v[8];
        int lat;
        logic [63:0] want;
        v = '{80, 70, 60, 50, 40, 30, 20, 10};
        accept(0, pack(v), 1'b0);
        wait_done(0, lat);
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        want = pack(v);
        n_chk++;
        if (lat != 9) begin
            n_fail++;
            $display("FAIL reverse latency: got %0d edges required 9", lat);
        end
        n_chk++;
        if (a_out_data !== want || a_out_swaps !== CWA'(28)) begin
            n_fail++;
            $display("FAIL reverse const: got %h/%0d required %h/28", a_out_data, a_out_swaps, want);
        end
        check_out(0, "reverse");
    endtask

    task automatic test_patterns;
        int v[8];
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        run(0, pack(v), 1'b0, "sorted");
        v = '{5, 200, 5, 0, 255, 9, 9, 0};
        run(0, pack(v), 1'b0, "dups");
        v = '{3, 1, 4, 1, 5, 9, 2, 6};
        run(0, pack(v), 1'b1, "desc");
    endtask

    task automatic test_backpressure;
        logic [63:0] v1, v2;
        exp_t e;
        int lat;
        v1 = {$urandom, $urandom};
        v2 = {$urandom, $urandom};
        accept(0, v1, 1'b0);
        wait_done(0, lat);
        e = sb[0];
        drive_in(0, 1'b1, 1'b1, v2);
        repeat (5) begin
            @(posedge clk); #1;
            n_chk++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== e.data ||
                32'(a_out_swaps) !== e.swaps) begin
                n_fail++;
                $display("FAIL bp_hold: vld=%b rdy=%b data=%h swaps=%0d required 1/0/%h/%0d",
                         a_out_valid, a_in_ready, a_out_data, a_out_swaps, e.data, e.swaps);
            end
        end
        check_out(0, "bp_first");
        n_chk++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_early_accept: in_ready=%b required 1", a_in_ready);
        end
        push_exp(0, v2, 1'b1);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 1'b1, v2);
        n_chk++;
        if (a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: in_ready=%b required 0", a_in_ready);
        end
        wait_done(0, lat);
        n_chk++;
        if (lat != NA + 1) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d required %0d", lat, NA + 1);
        end
        check_out(0, "bp_second");
    endtask

    task automatic test_reset_mid;
        int v[8];
        v = '{80, 70, 60, 50, 40, 30, 20, 10};
        accept(0, pack(v), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_swaps !== '0 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: vld=%b data=%h swaps=%0d rdy=%b required 0",
                     a_out_valid, a_out_data, a_out_swaps, a_in_ready);
        end
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run(0, {64{1'b1}}, 1'b0, "all_ff");
    endtask

    task automatic test_random;
        logic [63:0] d;
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 30; i++) begin
                d = {$urandom, $urandom};
                run(sel, d, 1'(i % 2), "random");
            end
            for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'($urandom_range(0, 3));
            d[15:8] = d[7:0];
            run(sel, d, 1'b0, "rand_dup_asc");
            run(sel, d, 1'b1, "rand_dup_desc");
        end
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_patterns();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
